m_rout_uart: RTL and testbench

- Downstream consumer of the processor's 32-bit result register (the $30 write-back output that also drives the LEDs/VIO).
- Detects each change of that word, queues it in a small FIFO, and streams it as 8 uppercase ASCII hex characters plus CR LF over a UART TX line (8N1, LSB first).
- Gives the board a serial trace of program results without VIO.

---
 rtl/m_rout_uart_pkg.sv | 33 +++
 rtl/m_sync_fifo.sv | 70 +++++++
 rtl/m_rout_uart.sv | 199 +++++++++++++++++++
 tb/tb_m_rout_uart.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/m_rout_uart_pkg.sv
// Shared types and constants for the result-word UART tracer.
// Optional macro ROUT_UART_PARITY_EN adds the PARITY state (8E1 framing).
package m_rout_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_DATA,
`ifdef ROUT_UART_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_e;

    localparam logic [7:0] CHR_0  = 8'h30;
    localparam logic [7:0] CHR_A  = 8'h41;
    localparam logic [7:0] CHR_CR = 8'h0D;
    localparam logic [7:0] CHR_LF = 8'h0A;

    localparam int CHARS_PER_WORD = 10;

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nib);
        logic [7:0] res;
        if (nib < 4'd10) begin
            res = CHR_0 + {4'b0000, nib};
        end else begin
            res = CHR_A + {4'b0000, nib} - 8'd10;
        end
        return res;
    endfunction

endpackage

// File: rtl/m_sync_fifo.sv
// Single-clock FIFO with pointer + count; a push on a full FIFO is still
// accepted when a pop happens in the same cycle.
module m_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (count_q == COUNT_FULL);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/m_rout_uart.sv
// Streams every change of the processor result word as 8 hex chars + CR LF
// over UART. Define ROUT_UART_PARITY_EN for 8E1 framing instead of 8N1.
module m_rout_uart
    import m_rout_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_W       = 32
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic [DATA_W-1:0] w_rout,
    output logic              w_txd,
    output logic              w_busy,
    output logic [7:0]        w_drop_cnt
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    IDX_LAST = 4'(CHARS_PER_WORD - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] prev_q;
    logic [DATA_W-1:0] word_q, word_d;
    logic [3:0]        idx_q, idx_d;
    logic [2:0]        bit_q, bit_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic              txd_q, txd_d;
    logic [7:0]        drop_q;
`ifdef ROUT_UART_PARITY_EN
    logic              par_q, par_d;
`endif

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              drop;
    logic              cnt_done;
    logic [3:0]        nib;
    logic [7:0]        char_sel;

    assign push = (w_rout != prev_q);
    assign drop = push && fifo_full && !pop;

    m_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (w_clk),
        .rst_ni  (w_rst_n),
        .push_i  (push),
        .data_i  (w_rout),
        .pop_i   (pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Nibble for char i sits at bit 28-4i, i.e. 4*(7-i) = {~i, 2'b00}.
    always_comb begin
        nib = 4'(word_q >> {1'b0, ~idx_q[2:0], 2'b00});
        case (idx_q)
            4'd8:    char_sel = CHR_CR;
            4'd9:    char_sel = CHR_LF;
            default: char_sel = nibble_to_ascii(nib);
        endcase
    end

    assign cnt_done = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef ROUT_UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    word_d  = fifo_dout;
                    idx_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d = char_sel;
`ifdef ROUT_UART_PARITY_EN
                par_d   = ^char_sel;
`endif
                cnt_d   = '0;
                state_d = ST_START;
            end
            ST_START: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_done) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef ROUT_UART_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef ROUT_UART_PARITY_EN
            ST_PARITY: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_done) begin
                    cnt_d   = '0;
                    idx_d   = idx_q + 1'b1;
                    state_d = (idx_q == IDX_LAST) ? ST_IDLE : ST_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The line level is registered from the next state so w_txd never glitches.
    always_comb begin
        case (state_d)
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[0];
`ifdef ROUT_UART_PARITY_EN
            ST_PARITY: txd_d = par_d;
`endif
            default:   txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q <= ST_IDLE;
            prev_q  <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            drop_q  <= '0;
`ifdef ROUT_UART_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            prev_q  <= w_rout;
            word_q  <= word_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 1'b1;
            end
`ifdef ROUT_UART_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign w_txd      = txd_q;
    assign w_busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign w_drop_cnt = drop_q;

endmodule

// File: tb/tb_m_rout_uart.sv
// Directed bench for m_rout_uart: decodes w_txd into bytes and compares
// them with hand-computed hex/CR/LF characters.
module tb_m_rout_uart;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int HALF  = CPB / 2;
`ifdef ROUT_UART_PARITY_EN
    localparam bit PAR_EN = 1'b1;
    localparam int BITS   = 11;
`else
    localparam bit PAR_EN = 1'b0;
    localparam int BITS   = 10;
`endif
    localparam int FRAME = 10 * BITS * CPB;

    logic        w_clk;
    logic        w_rst_n;
    logic [31:0] w_rout;
    logic        w_txd;
    logic        w_busy;
    logic [7:0]  w_drop_cnt;

    int vecCount;
    int missCount;
    int framingErrs;
    int parityErrs;

    logic [7:0] rxQ[$];

    typedef struct {
        logic [31:0]      word;
        logic [0:9][7:0]  chars;
    } vec_t;

    localparam int NVEC = 5;
    vec_t vecs[NVEC];

    m_rout_uart #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_W       (32)
    ) dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .w_rout     (w_rout),
        .w_txd      (w_txd),
        .w_busy     (w_busy),
        .w_drop_cnt (w_drop_cnt)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Line receiver: finds a start bit, samples every bit near its centre,
    // and throws away any frame interrupted by reset.
    initial begin
        int rxPhase;
        int rxT;
        int slot;
        logic [7:0] rxByte;
        logic rxPar;
        rxPhase = 0;
        rxT = 0;
        rxByte = '0;
        rxPar = 1'b0;
        forever begin
            @(negedge w_clk);
            if (!w_rst_n) begin
                rxPhase = 0;
            end else if (rxPhase == 0) begin
                if (w_txd == 1'b0) begin
                    rxPhase = 1;
                    rxT = 0;
                end
            end else begin
                rxT++;
                if (rxT == HALF) begin
                    if (w_txd) rxPhase = 0;
                end else if (rxT > HALF && ((rxT - HALF) % CPB) == 0) begin
                    slot = (rxT - HALF) / CPB;
                    if (slot <= 8) begin
                        rxByte[slot-1] = w_txd;
                    end else if (PAR_EN && slot == 9) begin
                        rxPar = w_txd;
                    end else begin
                        if (w_txd) begin
                            rxQ.push_back(rxByte);
                            if (PAR_EN && (rxPar != ^rxByte)) parityErrs++;
                        end else begin
                            framingErrs++;
                        end
                        rxPhase = 0;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkRange(input string name, input int actual,
                              input int lo, input int hi);
        vecCount++;
        if (actual < lo || actual > hi) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] word);
        w_rout = word;
    endtask

    task automatic waitChars(input int n, input string name);
        int t;
        t = 0;
        while (rxQ.size() < n && t < 6000) begin
            @(negedge w_clk);
            t++;
        end
        checkOutput(name, rxQ.size(), n);
    endtask

    task automatic waitIdle();
        int t;
        t = 0;
        while (w_busy && t < 6000) begin
            @(negedge w_clk);
            t++;
        end
    endtask

    function automatic logic [7:0] expChar(input logic [31:0] w, input int i);
        string s;
        s = $sformatf("%08X", w);
        if (i < 8) return s[i];
        if (i == 8) return 8'h0D;
        return 8'h0A;
    endfunction

    function automatic logic [7:0] rxAt(input int i);
        if (i < rxQ.size()) return rxQ[i];
        return 8'hFF;
    endfunction

    initial begin
        int cnt;
        int firstLow;
        int t;

        vecCount    = 0;
        missCount   = 0;
        framingErrs = 0;
        parityErrs  = 0;

        vecs[0] = '{32'h0000001E, {8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h45, 8'h0D, 8'h0A}};
        vecs[1] = '{32'hDEADBEEF, {8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A}};
        vecs[2] = '{32'h12345678, {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A}};
        vecs[3] = '{32'hA5C3F09B, {8'h41, 8'h35, 8'h43, 8'h33, 8'h46, 8'h30, 8'h39, 8'h42, 8'h0D, 8'h0A}};
        vecs[4] = '{32'h00000000, {8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}};

        w_rst_n = 1'b0;
        w_rout  = 32'h0;
        repeat (3) @(negedge w_clk);
        checkOutput("reset_txd", w_txd, 1'b1);
        checkOutput("reset_busy", w_busy, 1'b0);
        checkOutput("reset_drop", w_drop_cnt, 8'd0);
        w_rst_n = 1'b1;

        // Unchanged zero word after reset must never produce traffic.
        cnt = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge w_clk);
            if (w_txd !== 1'b1 || w_busy !== 1'b0) cnt++;
        end
        checkOutput("idle_quiet", cnt, 0);
        checkOutput("idle_rx_bytes", rxQ.size(), 0);

        for (int v = 0; v < NVEC; v++) begin
            rxQ.delete();
            applyStimulus(vecs[v].word);
            cnt = 0;
            firstLow = 0;
            do begin
                @(negedge w_clk);
                cnt++;
                if (firstLow == 0 && w_txd === 1'b0) firstLow = cnt;
            end while (w_busy && cnt < 3000);
            checkRange($sformatf("v%0d_start_latency", v), firstLow, 1, 3);
            checkRange($sformatf("v%0d_frame_cycles", v), cnt, FRAME + 10, FRAME + 13);
            checkOutput($sformatf("v%0d_char_count", v), rxQ.size(), 10);
            for (int i = 0; i < 10; i++) begin
                checkOutput($sformatf("v%0d_char%0d", v, i), rxAt(i), vecs[v].chars[i]);
            end
            checkOutput($sformatf("v%0d_drop", v), w_drop_cnt, 8'd0);
        end

        // Overflow: six distinct words land while a frame is already in DATA.
        rxQ.delete();
        applyStimulus(32'h11111111);
        t = 0;
        while (w_txd !== 1'b0 && t < 20) begin
            @(negedge w_clk);
            t++;
        end
        checkOutput("ovf_start_seen", w_txd, 1'b0);
        repeat (6) @(negedge w_clk);
        for (int k = 1; k <= 6; k++) begin
            applyStimulus(32'(k) << 28);
            @(negedge w_clk);
        end
        checkOutput("ovf_drop_cnt", w_drop_cnt, 8'd2);
        checkOutput("ovf_busy", w_busy, 1'b1);
        waitChars(50, "ovf_char_count");
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("ovf_first_char%0d", i), rxAt(i), expChar(32'h11111111, i));
        end
        for (int f = 1; f <= 4; f++) begin
            for (int i = 0; i < 10; i++) begin
                checkOutput($sformatf("ovf_q%0d_char%0d", f, i), rxAt(f * 10 + i),
                            expChar(32'(f) << 28, i));
            end
        end
        waitIdle();
        checkOutput("ovf_no_extra", rxQ.size(), 50);
        checkOutput("ovf_idle_busy", w_busy, 1'b0);

        // Reset in the middle of char 3, then the word is re-captured.
        rxQ.delete();
        applyStimulus(32'h00000005);
        waitChars(3, "rst_pre_chars");
        repeat (12) @(negedge w_clk);
        checkOutput("rst_pre_txd", w_txd, 1'b0);
        #1;
        w_rst_n = 1'b0;
        #1;
        checkOutput("rst_txd", w_txd, 1'b1);
        checkOutput("rst_drop", w_drop_cnt, 8'd0);
        checkOutput("rst_busy", w_busy, 1'b0);
        @(negedge w_clk);
        @(negedge w_clk);
        rxQ.delete();
        w_rst_n = 1'b1;
        waitChars(10, "rst_char_count");
        for (int i = 0; i < 10; i++) begin
            checkOutput($sformatf("rst_char%0d", i), rxAt(i), expChar(32'h00000005, i));
        end
        waitIdle();
        checkOutput("rst_idle_busy", w_busy, 1'b0);
        checkOutput("rst_drop_after", w_drop_cnt, 8'd0);

        checkOutput("framing_errors", framingErrs, 0);
        checkOutput("parity_errors", parityErrs, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
